// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-side signal bundle for sync_fifo_param.
// master = the logic driving writes/reads, slave = the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             walmost_full;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wdata, rinc,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock elastic FIFO with occupancy count, almost-full/empty thresholds and
// sticky overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 2**ASIZE - 2,
  parameter int AE_LEVEL = 2
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);
  localparam int             DEPTH    = 2**ASIZE;
  localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AE_LEVEL);
  localparam logic [ASIZE:0] ONE      = (ASIZE+1)'(1);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE:0]   waddr_q, waddr_d;
  logic [ASIZE:0]   raddr_q, raddr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty, wr_en, rd_en;

  // Flags decode the registered count, so acceptance always sees pre-edge state.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign wr_en = bus.winc && !full;
  assign rd_en = bus.rinc && !empty;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (bus.winc && full);
    underflow_d = underflow_q | (bus.rinc && empty);
    if (wr_en) waddr_d = waddr_q + ONE;
    if (rd_en) raddr_d = raddr_q + ONE;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      waddr_q     <= '0;
      raddr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[waddr_q[ASIZE-1:0]] <= bus.wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rdata = mem_q[raddr_q[ASIZE-1:0]];
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst)        rdata_q <= '0;
    else if (rd_en) rdata_q <= mem_q[raddr_q[ASIZE-1:0]];
  end

  assign bus.rdata = rdata_q;
`endif

  assign bus.count         = count_q;
  assign bus.wfull         = full;
  assign bus.rempty        = empty;
  assign bus.walmost_full  = (count_q >= AF_CNT);
  assign bus.ralmost_empty = (count_q <= AE_CNT);
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_sync_fifo_param;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  sync_fifo_param_if #(.DSIZE(8), .ASIZE(4)) bus ();

  sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  logic       ovf_m;
  logic       unf_m;
  logic [7:0] rdata_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"},         32'(bus.count),       32'(q.size()));
    check({tag, ".wfull"},         32'(bus.wfull),       32'(q.size() == DEPTH));
    check({tag, ".walmost_full"},  32'(bus.walmost_full),  32'(q.size() >= AF));
    check({tag, ".rempty"},        32'(bus.rempty),      32'(q.size() == 0));
    check({tag, ".ralmost_empty"}, 32'(bus.ralmost_empty), 32'(q.size() <= AE));
    check({tag, ".overflow"},      32'(bus.overflow),    32'(ovf_m));
    check({tag, ".underflow"},     32'(bus.underflow),   32'(unf_m));
`ifdef SYNC_FIFO_FWFT_EN
    if (q.size() != 0) check({tag, ".rdata"}, 32'(bus.rdata), 32'(q[0]));
`else
    check({tag, ".rdata"}, 32'(bus.rdata), 32'(rdata_m));
`endif
  endtask

  // Apply one cycle of stimulus, advance the model by the FIFO's rules, compare.
  task automatic step(input string tag, input logic r_st, input logic w,
                      input logic [7:0] wd, input logic r);
    bit was_full, was_empty;
    rst       = r_st;
    bus.winc  = w;
    bus.wdata = wd;
    bus.rinc  = r;
    @(posedge clk);
    #1;
    if (r_st) begin
      q.delete();
      ovf_m   = 1'b0;
      unf_m   = 1'b0;
      rdata_m = 8'h00;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (w && was_full)  ovf_m = 1'b1;
      if (r && was_empty) unf_m = 1'b1;
      if (r && !was_empty) rdata_m = q.pop_front();
      if (w && !was_full)  q.push_back(wd);
    end
    compare_all(tag);
  endtask

  initial begin
    logic [7:0] d;
    int wprob, rprob;

    rst       = 1'b1;
    bus.winc  = 1'b0;
    bus.wdata = 8'h00;
    bus.rinc  = 1'b0;
    q.delete();
    ovf_m   = 1'b0;
    unf_m   = 1'b0;
    rdata_m = 8'h00;

    step("reset", 1'b1, 1'b0, 8'h00, 1'b0);
    step("reset2", 1'b1, 1'b1, 8'h77, 1'b1);

    // Fill to full, watching thresholds on every count
    for (int i = 0; i < DEPTH; i++) step($sformatf("fill%0d", i), 1'b0, 1'b1, 8'(i), 1'b0);

    // Write while full: rejected, overflow sticks
    step("ovf", 1'b0, 1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < DEPTH; i++) step($sformatf("drain%0d", i), 1'b0, 1'b0, 8'h00, 1'b1);
    step("drained", 1'b0, 1'b0, 8'h00, 1'b0);

    // Read while empty, then simultaneous read+write on empty
    step("unf", 1'b0, 1'b0, 8'h00, 1'b1);
    step("wr_rd_empty", 1'b0, 1'b1, 8'h55, 1'b1);
    step("rd55", 1'b0, 1'b0, 8'h00, 1'b1);

    // Half full, streaming for 40 cycles with wrapping pointers
    step("rst_half", 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step("half_fill", 1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) step($sformatf("stream%0d", i), 1'b0, 1'b1, 8'(i), 1'b1);

    // Simultaneous read+write while full: only the read goes through
    for (int i = 0; i < 8; i++) step("top_up", 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    step("wr_rd_full", 1'b0, 1'b1, 8'hEE, 1'b1);

    // Reset mid-stream with winc held
    step("rst_mid0", 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    step("rst_mid", 1'b1, 1'b1, 8'h99, 1'b0);
    step("post_rst_rd", 1'b0, 1'b0, 8'h00, 1'b1);

`ifdef SYNC_FIFO_FWFT_EN
    step("fwft_rst", 1'b1, 1'b0, 8'h00, 1'b0);
    step("fwft_wr", 1'b0, 1'b1, 8'h3C, 1'b0);
    check("fwft_show", 32'(bus.rdata), 32'h3C);
    step("fwft_pop", 1'b0, 1'b0, 8'h00, 1'b1);
    check("fwft_empty", 32'(bus.rempty), 32'h1);
`endif

    // Randomized traffic with varying write/read pressure and rare resets
    for (int blk = 0; blk < 12; blk++) begin
      wprob = $urandom_range(10, 90);
      rprob = $urandom_range(10, 90);
      for (int i = 0; i < 150; i++) begin
        d = 8'($urandom);
        step($sformatf("rnd%0d_%0d", blk, i),
             ($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < wprob), d,
             ($urandom_range(0, 99) < rprob));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
